// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of a zero-latency instruction ROM.
// It owns the PC, presents it on rom_address, and registers the returned word
// together with its PC. Decode pulls instructions over a valid/ready handshake.
// Supports redirect with flush, halt on a configurable encoding, a sticky
// misaligned-redirect flag and a count of completed handshakes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rom_address       current PC to the ROM
//   rom_instruction   ROM word for rom_address (same cycle)
//   redirect_valid    one-cycle pulse: load redirect_target and flush
//   redirect_target   new PC (low two bits dropped, flagged if nonzero)
//   out_valid/ready   handshake to decode
//   out_instruction   registered instruction
//   out_pc            address of out_instruction
//   halted            high while stopped on HALT_INSTR
//   align_err         sticky misaligned-redirect flag
//   fetch_count       completed handshakes since reset (wraps)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        align_err,
    output logic [31:0] fetch_count
);

    typedef enum logic {S_FETCH, S_HALTED} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        valid_nxt;
    logic [31:0] instr_nxt, opc_nxt, cnt_nxt;
    logic        align_nxt;
    logic        handshake, slot_free;

    assign rom_address = pc;
    assign halted      = (state == S_HALTED);
    assign handshake   = out_valid & out_ready;
    assign slot_free   = !out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_FETCH;
            pc              <= RESET_PC;
            out_valid       <= 1'b0;
            out_instruction <= 32'h0;
            out_pc          <= 32'h0;
            align_err       <= 1'b0;
            fetch_count     <= 32'h0;
        end else begin
            state           <= state_nxt;
            pc              <= pc_nxt;
            out_valid       <= valid_nxt;
            out_instruction <= instr_nxt;
            out_pc          <= opc_nxt;
            align_err       <= align_nxt;
            fetch_count     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        valid_nxt = out_valid;
        instr_nxt = out_instruction;
        opc_nxt   = out_pc;
        align_nxt = align_err;
        cnt_nxt   = fetch_count;

        // A word flushed by a same-cycle redirect is not counted as delivered.
        if (handshake && !redirect_valid)
            cnt_nxt = fetch_count + 32'd1;

        if (redirect_valid) begin
            pc_nxt    = {redirect_target[31:2], 2'b00};
            valid_nxt = 1'b0;
            state_nxt = S_FETCH;
            if (redirect_target[1:0] != 2'b00)
                align_nxt = 1'b1;
        end else begin
            case (state)
                S_FETCH: begin
                    if (slot_free) begin
                        instr_nxt = rom_instruction;
                        opc_nxt   = pc;
                        valid_nxt = 1'b1;
                        // PC stays on the halt word so a later redirect is the only way on.
                        if (rom_instruction == HALT_INSTR)
                            state_nxt = S_HALTED;
                        else
                            pc_nxt = pc + 32'd4;
                    end
                end
                S_HALTED: begin
                    if (handshake)
                        valid_nxt = 1'b0;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_address;
    logic [31:0] rom_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        halted;
    logic        align_err;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] halt_addr = 32'h0000_0001; // misaligned: never matches a PC

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .HALT_INSTR(HALT)) dut (
        .clk(clk), .rst(rst), .rom_address(rom_address),
        .rom_instruction(rom_instruction), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .out_valid(out_valid),
        .out_ready(out_ready), .out_instruction(out_instruction),
        .out_pc(out_pc), .halted(halted), .align_err(align_err),
        .fetch_count(fetch_count)
    );

    // ROM contents: word i holds i+0x100, except one optional halt address.
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        if (a == halt_addr) return HALT;
        return (a >> 2) + 32'h100;
    endfunction

    always_comb rom_instruction = rom_fn(rom_address);

    // Reference model state
    logic [31:0] m_pc, m_instr, m_opc, m_count;
    logic        m_valid, m_halted, m_align;

    function automatic logic [130:0] dut_vec();
        return {out_valid, halted, align_err, out_instruction, out_pc, fetch_count, rom_address};
    endfunction

    function automatic logic [130:0] mdl_vec();
        return {m_valid, m_halted, m_align, m_instr, m_opc, m_count, m_pc};
    endfunction

    // Drive one cycle of inputs, advance the model by the rules, then sample #1 after the edge.
    task automatic step(input logic r, input logic rv, input logic [31:0] rt, input logic rdy);
        logic [31:0] w;
        logic        hs;
        rst = r; redirect_valid = rv; redirect_target = rt; out_ready = rdy;
        if (r) begin
            m_pc = 0; m_valid = 0; m_instr = 0; m_opc = 0;
            m_halted = 0; m_align = 0; m_count = 0;
        end else begin
            hs = m_valid && rdy;
            if (hs && !rv) m_count = m_count + 1;
            if (rv) begin
                m_pc = rt & ~32'h3;
                m_valid = 0;
                m_halted = 0;
                if (rt[1:0] != 0) m_align = 1;
            end else if (!m_halted && (!m_valid || rdy)) begin
                w = rom_fn(m_pc);
                m_instr = w; m_opc = m_pc; m_valid = 1;
                if (w == HALT) m_halted = 1;
                else m_pc = m_pc + 4;
            end else if (m_halted && hs) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 32'h43, 1);
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL reset: got %h exp %h", dut_vec(), mdl_vec());
        end
        checks++;
        if (rom_address !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_const: addr %h valid %b exp 0/0", rom_address, out_valid);
        end
    endtask

    task automatic test_free_run();
        step(1, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL free_run[%0d]: got %h exp %h", i, dut_vec(), mdl_vec());
            end
            checks++;
            if (out_pc !== 32'(i * 4) || out_instruction !== 32'(i + 32'h100) || fetch_count !== 32'(i)) begin
                errors++;
                $display("FAIL free_run_seq[%0d]: pc %h ins %h cnt %0d", i, out_pc, out_instruction, fetch_count);
            end
        end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            checks++;
            if (out_pc !== 32'h8 || out_instruction !== 32'h102 || rom_address !== 32'hC || !out_valid) begin
                errors++;
                $display("FAIL stall[%0d]: pc %h ins %h addr %h v %b exp 8/102/c/1", i, out_pc, out_instruction, rom_address, out_valid);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 1);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL stall_release[%0d]: got %h exp %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] cnt;
        step(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        cnt = fetch_count;
        step(0, 1, 32'h40, 0);
        checks++;
        if (out_valid !== 1'b0 || rom_address !== 32'h40 || fetch_count !== cnt) begin
            errors++;
            $display("FAIL redirect_stall: v %b addr %h cnt %0d exp 0/40/%0d", out_valid, rom_address, fetch_count, cnt);
        end
        step(0, 0, 0, 1);
        checks++;
        if (out_pc !== 32'h40 || out_instruction !== 32'h110 || fetch_count !== cnt || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL redirect_resume: pc %h ins %h cnt %0d exp 40/110/%0d", out_pc, out_instruction, fetch_count, cnt);
        end
    endtask

    task automatic test_halt();
        halt_addr = 32'h10;
        step(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        checks++;
        if (!halted || out_pc !== 32'h10 || out_instruction !== HALT || rom_address !== 32'h10 || !out_valid) begin
            errors++;
            $display("FAIL halt_capture: h %b pc %h ins %h addr %h v %b", halted, out_pc, out_instruction, rom_address, out_valid);
        end
        step(0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || !halted || rom_address !== 32'h10 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL halt_drain: got %h exp %h", dut_vec(), mdl_vec());
        end
        step(0, 0, 0, 1);
        step(0, 1, 32'h20, 1);
        checks++;
        if (halted !== 1'b0 || rom_address !== 32'h20) begin
            errors++;
            $display("FAIL halt_redirect: h %b addr %h exp 0/20", halted, rom_address);
        end
        step(0, 0, 0, 1);
        checks++;
        if (out_pc !== 32'h20 || !out_valid || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL halt_resume: pc %h v %b exp 20/1", out_pc, out_valid);
        end
        halt_addr = 32'h1;
    endtask

    task automatic test_misalign_wrap();
        step(1, 0, 0, 1);
        step(0, 1, 32'h43, 1);
        checks++;
        if (rom_address !== 32'h40 || align_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign: addr %h ae %b exp 40/1", rom_address, align_err);
        end
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        checks++;
        if (out_pc !== 32'h0 || rom_address !== 32'h4 || align_err !== 1'b1 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL wrap: pc %h addr %h ae %b exp 0/4/1", out_pc, rom_address, align_err);
        end
    endtask

    task automatic test_midreset();
        step(0, 1, 32'h102, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if (dut_vec() !== {3'b000, 32'h0, 32'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL midreset: got %h exp all zero", dut_vec());
        end
    endtask

    task automatic test_random();
        logic        r, rv, rdy;
        logic [31:0] rt;
        halt_addr = 32'h30;
        step(1, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                              : 32'($urandom_range(0, 80));
            step(r, rv, rt, rdy);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h exp %h", i, dut_vec(), mdl_vec());
            end
        end
        halt_addr = 32'h1;
    endtask

    initial begin
        rst = 1; redirect_valid = 0; redirect_target = 0; out_ready = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_misalign_wrap();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the combinational instruction ROM. It owns the program counter, drives the ROM address, and captures the returned word into an output register with its PC. It hands instructions to the decode stage over a valid/ready handshake. It also supports redirect (branch/jump) with flush, halt detection and fetch counting.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops sequential fetch once captured.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
rom_address  output  32  PC presented to instruction ROM; equals internal pc register.
rom_instruction  input  32  combinational ROM data for rom_address, same cycle.
redirect_valid  input  1  one-cycle pulse: load new PC and flush.
redirect_target  input  32  new PC when redirect_valid=1.
out_valid  output  1  out_instruction/out_pc hold a valid fetched instruction.
out_ready  input  1  decode accepts when out_valid & out_ready.
out_instruction  output  32  registered instruction.
out_pc  output  32  address out_instruction was fetched from.
halted  output  1  1 while in HALTED state.
align_err  output  1  sticky; set by a misaligned redirect target.
fetch_count  output  32  number of completed out handshakes since reset.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=FETCH, out_valid=0, out_instruction=0, out_pc=0, halted=0, align_err=0, fetch_count=0. Reset overrides every other input; it is effective mid-stream with no residue.
- rom_address = pc, combinational from the register. The ROM is zero-latency, so the word at pc is sampled on the same edge.
- Define "slot free" = !out_valid | out_ready.
- FETCH state, priority order per edge:
  1. redirect_valid=1: pc = {redirect_target[31:2],2'b00}, out_valid=0 (flush; any held instruction is dropped and not counted), no capture. If redirect_target[1:0]!=0, set align_err. This produces one bubble cycle.
  2. Otherwise, if slot free: out_instruction=rom_instruction, out_pc=pc, out_valid=1, pc=pc+4. Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. If rom_instruction==HALT_INSTR, go to HALTED and leave pc unchanged (no +4).
  3. Otherwise (stall: out_valid & !out_ready): hold pc and all out registers stable.
- HALTED state: halted=1. No new capture and pc holds. The captured HALT word stays valid until handshaken; then out_valid=0. redirect_valid=1 applies rule 1 and returns to FETCH (halted=0 next cycle).
- fetch_count increments on each cycle with out_valid & out_ready & !redirect_valid. It wraps at 2^32.
- Handshake rules: out_instruction/out_pc must not change while out_valid=1 and out_ready=0, unless a redirect occurs. A simultaneous handshake and capture in one cycle is legal (back-to-back, one per cycle).
- Throughput: 1 instruction/cycle with out_ready tied high. First out_valid appears 1 cycle after rst deasserts.
- align_err clears only on rst.

Test Plan:
- Reset then free-run, ROM[i]=i+0x100, out_ready=1 -> out_valid from cycle 1; out_pc 0,4,8,... with out_instruction 0x100,0x101,...; after 5 cycles fetch_count=4 or 5 per handshakes counted, checked each cycle.
- Stall: hold out_ready=0 for 3 cycles with out_pc=8 valid -> out_pc/out_instruction remain 8/0x102 and rom_address stays 12; release -> 12 captured next edge, no skip or duplicate.
- Redirect while stalled: out_valid=1 at pc 8, pulse redirect_target=0x40 -> next cycle out_valid=0, rom_address=0x40; following cycle out_pc=0x40; fetch_count unchanged by the flushed word.
- Halt: ROM[0x10]=HALT_INSTR -> captured with out_pc=0x10, halted=1, rom_address frozen at 0x10; after handshake out_valid=0. Redirect to 0x20 -> halted=0 and fetch resumes at 0x20.
- Misaligned/wrap: redirect_target=0x43 -> pc=0x40, align_err=1 and stays 1. Redirect to 0xFFFF_FFFC -> next fetch at 0x0.
- Mid-operation reset: assert rst during a stall with out_valid=1 -> next cycle all outputs are at reset values and rom_address=RESET_PC.
